// File: rtl/kyber_pkg.sv
// Shared constants and encodings for the Kyber polynomial datapath.
package kyber_pkg;

    localparam int KYBER_W = 12;
    localparam int KYBER_Q = 3329;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/modaddsub_pipe_if.sv
// Valid/ready bus for the multi-lane modular add/subtract pipeline.
interface modaddsub_pipe_if
    import kyber_pkg::*;
#(
    parameter int W     = KYBER_W,
    parameter int LANES = 4
);

    logic               in_valid;
    logic               in_ready;
    op_e                in_op;
    logic [LANES*W-1:0] in_a;
    logic [LANES*W-1:0] in_b;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_c;
    logic               range_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, range_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, range_err
    );

endinterface

// File: rtl/modaddsub_lane.sv
// One lane of the mod-Q add/subtract pipe: raw A+/-B in stage 1, single
// conditional correction by Q in stage 2.
module modaddsub_lane
    import kyber_pkg::*;
#(
    parameter int W = KYBER_W,
    parameter int Q = KYBER_Q
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s1_load_i,
    input  logic         s2_load_i,
    input  op_e          op_i,
    input  op_e          s1_op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         range_hit_o,
    output logic [W-1:0] c_o
);

    localparam logic [W-1:0] Q_W = W'(Q);
    localparam logic [W:0]   Q_R = (W+1)'(Q);

    logic [W:0]   r_q, r_d;
    logic [W-1:0] c_q, c_d;

    always_comb begin
        if (op_i == OP_SUB) begin
            r_d = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            r_d = {1'b0, a_i} + {1'b0, b_i};
        end
        range_hit_o = (a_i >= Q_W) || (b_i >= Q_W);
    end

    // Only the low W bits of R +/- Q survive, so the correction runs at W bits;
    // the sign/compare decisions still look at the full W+1 bit raw result.
    always_comb begin
        c_d = r_q[W-1:0];
        if (s1_op_i == OP_SUB) begin
            if (r_q[W]) begin
                c_d = r_q[W-1:0] + Q_W;
            end
        end else if (r_q >= Q_R) begin
            c_d = r_q[W-1:0] - Q_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            if (s1_load_i) begin
                r_q <= r_d;
            end
            if (s2_load_i) begin
                c_q <= c_d;
            end
        end
    end

    assign c_o = c_q;

endmodule

// File: rtl/modaddsub_pipe.sv
// Two-stage, LANES-wide modular add/subtract over Z_Q with valid/ready on
// both sides and a sticky out-of-range operand flag.
module modaddsub_pipe
    import kyber_pkg::*;
#(
    parameter int W     = KYBER_W,
    parameter int Q     = KYBER_Q,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    modaddsub_pipe_if.slave   bus_if
);

    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    op_e                op_q;
    logic               range_err_q, range_err_d;
    logic               s1_load, s2_load;
    logic               in_fire;
    logic               s2_fill;
    logic [LANES-1:0]   lane_hit;
    logic [LANES*W-1:0] out_c_w;

    // in_ready follows out_ready combinationally so a full pipe can
    // accept and deliver in the same cycle.
    assign s2_load = !s2_valid_q || bus_if.out_ready;
    assign s1_load = !s1_valid_q || s2_load;
    assign in_fire = bus_if.in_valid && s1_load;
    assign s2_fill = s2_load && s1_valid_q;

    always_comb begin
        s1_valid_d  = s1_load ? bus_if.in_valid : s1_valid_q;
        s2_valid_d  = s2_load ? s1_valid_q : s2_valid_q;
        range_err_d = range_err_q || (in_fire && (|lane_hit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            op_q        <= OP_ADD;
            range_err_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            range_err_q <= range_err_d;
            if (in_fire) begin
                op_q <= bus_if.in_op;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        modaddsub_lane #(
            .W (W),
            .Q (Q)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .s1_load_i   (in_fire),
            .s2_load_i   (s2_fill),
            .op_i        (bus_if.in_op),
            .s1_op_i     (op_q),
            .a_i         (bus_if.in_a[i*W +: W]),
            .b_i         (bus_if.in_b[i*W +: W]),
            .range_hit_o (lane_hit[i]),
            .c_o         (out_c_w[i*W +: W])
        );
    end

    assign bus_if.in_ready  = s1_load;
    assign bus_if.out_valid = s2_valid_q;
    assign bus_if.out_c     = out_c_w;
    assign bus_if.range_err = range_err_q;

endmodule
